trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised machine-mode trap controller for the CPU core: it arbitrates synchronous exceptions and up to `NUM_IRQ` level-sensitive interrupt lines, computes the trap target (direct or vectored `mtvec`), produces the CSR update set for trap entry and `mret`, and enforces a pipeline-flush blackout after every redirect. It sits between the execute stage, the interrupt sources, the CSR file and the PC-select logic.

## Interface
- `XLEN`, 64, datapath and CSR width.
- `NUM_IRQ`, 16, number of interrupt lines. Range 1..32; line i reports cause code i.
- `CODE_W`, 5, width of the cause-code field.
- `FLUSH_CYCLES`, 2, blackout length after a redirect. Must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `exc_en` in 1: exception request from the pipeline.
- `exc_code` in `CODE_W`: exception cause code.
- `exc_val` in `XLEN`: exception `mtval` value.
- `irq_pend` in `NUM_IRQ`: level-sensitive interrupt pending lines.
- `irq_mask` in `NUM_IRQ`: `mie` enable bits.
- `mret` in 1: `mret` retiring this cycle.
- `pc_addr` in `XLEN`: PC of the faulting or interrupted instruction.
- `mtvec` in `XLEN`: trap vector CSR.
- `priv_lvl` in 2: current privilege level.
- `mstatus_current` in `XLEN`: current `mstatus`.
- `trap_taken` out 1: one-cycle redirect-to-trap pulse.
- `pc_trap_next` out `XLEN`: trap target PC.
- `pc_ret_taken` out 1: one-cycle `mret` redirect pulse.
- `pc_ret` out `XLEN`: return PC.
- `csr_we` out 1: one-cycle strobe. The CSR file commits `mepc_next`, `mcause_next`, `mtval_next`, `mstatus_next` and `priv_lvl_next` when it is high.
- `mepc_next`, `mcause_next`, `mtval_next`, `mstatus_next` out `XLEN` each: CSR values to commit.
- `priv_lvl_next` out 2: new privilege level.
- `busy` out 1: blackout active; all inputs are ignored.

## Operation
- FSM has two states, `IDLE` and `FLUSH`, plus a down-counter `cnt` of width clog2(`FLUSH_CYCLES`+1).
- Interrupt eligibility:
  - `elig = irq_pend & irq_mask`.
  - Global enable `gie = (priv_lvl != 2'b11) | mstatus_current[3]`.
  - An interrupt is requested when `gie` is set and `elig` is non-zero.
  - The highest-index eligible line wins.
- Priority in `IDLE`, highest first:
  1. `exc_en`
  2. Interrupt request
  3. `mret` with `priv_lvl == 11`
  4. `mret` with `priv_lvl != 11`: treated as an illegal-instruction exception with code 2 and mtval 0.
- Trap entry:
  - `mepc_next = pc_addr`.
  - `mcause_next = {is_irq, zeros, code}`, where code is zero-extended `CODE_W`.
  - `mtval_next` = `exc_val` for an exception, 0 for an interrupt.
  - `mstatus_next` = `mstatus_current` with MPIE[7] = MIE[3], MIE = 0, MPP[12:11] = `priv_lvl`.
  - `priv_lvl_next = 11`.
- Trap target:
  - Base = `{mtvec[XLEN-1:2], 2'b00}`.
  - Direct: `pc_trap_next` = base.
  - Vectored (see Configuration): for an interrupt, `pc_trap_next = base + 4*code`.
- `mret` (legal):
  - `pc_ret` = internally latched `mepc`, which is the last `mepc_next` committed.
  - `priv_lvl_next` = MPP.
  - `mstatus_next` = `mstatus_current` with MIE = MPIE, MPIE = 1, MPP = 00.
  - `mepc_next`, `mcause_next` and `mtval_next` hold their values; `csr_we` pulses.
- Any accepted event:
  - State → `FLUSH`, `cnt = FLUSH_CYCLES`.
  - In `FLUSH`, `cnt` decrements each edge; at `cnt == 1` the state returns to `IDLE`.
  - Events sampled while in `FLUSH` are dropped. Exceptions are not queued.
  - A still-pending level interrupt re-arbitrates in `IDLE`.
- Outputs other than the pulses hold their last value.

## Timing
- All outputs are registered.
- An event sampled at edge E0 produces `trap_taken` or `pc_ret_taken`, plus `csr_we`, high for exactly the cycle following E0, with all data outputs valid in that cycle.
- `busy` is high from E0 until edge E0+`FLUSH_CYCLES`.
- The earliest next acceptance is edge E0+`FLUSH_CYCLES`+1.
- Simultaneous `exc_en`, interrupt and `mret`: only the highest-priority event is taken; the others are discarded.
- Reset values:
  - All pulses, `busy`, `pc_trap_next`, `pc_ret`, `mepc_next`, `mcause_next`, `mtval_next`, `mstatus_next` and the latched `mepc` = 0.
  - `priv_lvl_next = 11`; state `IDLE`; `cnt = 0`.
- Reset asserted mid-`FLUSH` aborts the blackout immediately. Any pulse in flight is cleared asynchronously.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - `mtvec[1:0] == 01` selects vectored mode for interrupts.
  - Exceptions always use base.
  - Modes 1x behave as direct.
- `TRAP_VECTORED_EN` undefined: `mtvec[1:0]` is ignored and every trap uses base. The vector adder is not synthesised.

## Test plan
- Exception entry:
  - Stimulus: `exc_en=1`, code 2, `exc_val=0xDEAD`, `pc_addr=0x100`, `mtvec=0x200`, priv 00, MIE 1.
  - Response, next cycle: `trap_taken=1`, `pc_trap_next=0x200`, `mcause=2`, `mtval=0xDEAD`, `mepc=0x100`, `mstatus` MPIE=1/MIE=0/MPP=00, `priv_lvl_next=11`.
  - Then `busy` stays high for 2 cycles.
- Vectored interrupt, macro on:
  - Stimulus: `mtvec=0x201`, `irq_pend=0x0880`, `irq_mask=0xFFFF`, priv 11, MIE 1.
  - Response: code 11, `mcause=0x8000_0000_0000_000B`, `pc_trap_next=0x22C`, `mtval=0`.
  - With the macro off, the same stimulus gives `pc_trap_next=0x200`.
- Masking:
  - priv 11, MIE 0, irq line 3 pending → no trap.
  - The same stimulus with priv 00 → trap with code 3.
- Priority and blackout:
  - Stimulus: `exc_en` and `irq_pend[5]` asserted at the same edge, followed by a second `exc_en` during `busy`.
  - Response: one exception trap only; the second exception is dropped; irq 5 is not taken while `busy` is high.
- `mret` round trip:
  - Stimulus: after a trap with `mepc=0x100`, the CSR file reflects MPP=00, MPIE=1; then `mret` at priv 11.
  - Response: `pc_ret_taken=1`, `pc_ret=0x100`, `priv_lvl_next=00`, MIE=1, MPIE=1.
  - `mret` at priv 00 instead → illegal-instruction trap, `mcause=2`.
- Reset mid-`FLUSH`:
  - Stimulus: assert `rst` one cycle after `trap_taken`.
  - Response: all outputs at reset values, `busy=0`; a new `exc_en` is accepted on the first edge after `rst` deasserts.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt arbitration, trap target, CSR update set, post-redirect blackout.
// Optional feature macro: TRAP_VECTORED_EN (vectored mtvec mode for interrupts).
module trap_ctrl #(
  parameter int XLEN         = 64,
  parameter int NUM_IRQ      = 16,
  parameter int CODE_W       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_en,
  input  logic [CODE_W-1:0]  exc_code,
  input  logic [XLEN-1:0]    exc_val,
  input  logic [NUM_IRQ-1:0] irq_pend,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               mret,
  input  logic [XLEN-1:0]    pc_addr,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [1:0]         priv_lvl,
  input  logic [XLEN-1:0]    mstatus_current,
  output logic               trap_taken,
  output logic [XLEN-1:0]    pc_trap_next,
  output logic               pc_ret_taken,
  output logic [XLEN-1:0]    pc_ret,
  output logic               csr_we,
  output logic [XLEN-1:0]    mepc_next,
  output logic [XLEN-1:0]    mcause_next,
  output logic [XLEN-1:0]    mtval_next,
  output logic [XLEN-1:0]    mstatus_next,
  output logic [1:0]         priv_lvl_next,
  output logic               busy
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  logic             r_trap, r_ret, r_we;
  logic [XLEN-1:0]  r_pc_trap, r_pc_ret, r_mepc, r_mcause, r_mtval, r_mstatus;
  logic [1:0]       r_priv;

  logic             w_trap, w_ret, w_we;
  logic [XLEN-1:0]  w_pc_trap, w_pc_ret, w_mepc, w_mcause, w_mtval, w_mstatus;
  logic [1:0]       w_priv;

  logic [NUM_IRQ-1:0] w_elig;
  logic               w_gie, w_irq_req;
  logic [CODE_W-1:0]  w_irq_code;

  logic               w_ev_trap, w_ev_ret, w_ev_irq;
  logic [CODE_W-1:0]  w_ev_code;
  logic [XLEN-1:0]    w_ev_tval;
  logic [XLEN-1:0]    w_base, w_target, w_cause, w_ms_trap, w_ms_ret;
  logic               w_unused_mode;

  assign w_elig    = irq_pend & irq_mask;
  assign w_gie     = (priv_lvl != 2'b11) | mstatus_current[3];
  assign w_irq_req = w_gie & (|w_elig);

  // Later iterations overwrite earlier ones, so the highest eligible index wins.
  always_comb begin
    w_irq_code = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_elig[i]) w_irq_code = CODE_W'(i);
    end
  end

  always_comb begin
    w_ev_trap = 1'b0;
    w_ev_ret  = 1'b0;
    w_ev_irq  = 1'b0;
    w_ev_code = '0;
    w_ev_tval = '0;
    if (r_state == IDLE) begin
      if (exc_en) begin
        w_ev_trap = 1'b1;
        w_ev_code = exc_code;
        w_ev_tval = exc_val;
      end else if (w_irq_req) begin
        w_ev_trap = 1'b1;
        w_ev_irq  = 1'b1;
        w_ev_code = w_irq_code;
      end else if (mret && (priv_lvl == 2'b11)) begin
        w_ev_ret  = 1'b1;
      end else if (mret) begin
        // mret below M-mode raises illegal-instruction
        w_ev_trap = 1'b1;
        w_ev_code = CODE_W'(2);
      end
    end
  end

  assign w_base        = {mtvec[XLEN-1:2], 2'b00};
  assign w_unused_mode = ^mtvec[1:0];

`ifdef TRAP_VECTORED_EN
  assign w_target = (w_ev_irq && (mtvec[1:0] == 2'b01))
                  ? w_base + (XLEN'(w_ev_code) << 2) : w_base;
`else
  assign w_target = w_base;
`endif

  always_comb begin
    w_cause                = '0;
    w_cause[CODE_W-1:0]    = w_ev_code;
    w_cause[XLEN-1]        = w_ev_irq;
    w_ms_trap              = mstatus_current;
    w_ms_trap[7]           = mstatus_current[3];
    w_ms_trap[3]           = 1'b0;
    w_ms_trap[12:11]       = priv_lvl;
    w_ms_ret               = mstatus_current;
    w_ms_ret[3]            = mstatus_current[7];
    w_ms_ret[7]            = 1'b1;
    w_ms_ret[12:11]        = 2'b00;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_trap       = 1'b0;
    w_ret        = 1'b0;
    w_we         = 1'b0;
    w_pc_trap    = r_pc_trap;
    w_pc_ret     = r_pc_ret;
    w_mepc       = r_mepc;
    w_mcause     = r_mcause;
    w_mtval      = r_mtval;
    w_mstatus    = r_mstatus;
    w_priv       = r_priv;
    case (r_state)
      IDLE: begin
        if (w_ev_trap) begin
          w_trap    = 1'b1;
          w_we      = 1'b1;
          w_pc_trap = w_target;
          w_mepc    = pc_addr;
          w_mcause  = w_cause;
          w_mtval   = w_ev_tval;
          w_mstatus = w_ms_trap;
          w_priv    = 2'b11;
        end else if (w_ev_ret) begin
          w_ret     = 1'b1;
          w_we      = 1'b1;
          w_pc_ret  = r_mepc;
          w_mstatus = w_ms_ret;
          w_priv    = mstatus_current[12:11];
        end
        if (w_ev_trap || w_ev_ret) begin
          w_state_next = FLUSH;
          w_cnt_next   = CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_trap    <= 1'b0;
      r_ret     <= 1'b0;
      r_we      <= 1'b0;
      r_pc_trap <= '0;
      r_pc_ret  <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
      r_mtval   <= '0;
      r_mstatus <= '0;
      r_priv    <= 2'b11;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_trap    <= w_trap;
      r_ret     <= w_ret;
      r_we      <= w_we;
      r_pc_trap <= w_pc_trap;
      r_pc_ret  <= w_pc_ret;
      r_mepc    <= w_mepc;
      r_mcause  <= w_mcause;
      r_mtval   <= w_mtval;
      r_mstatus <= w_mstatus;
      r_priv    <= w_priv;
    end
  end

  assign trap_taken    = r_trap;
  assign pc_ret_taken  = r_ret;
  assign csr_we        = r_we;
  assign pc_trap_next  = r_pc_trap;
  assign pc_ret        = r_pc_ret;
  assign mepc_next     = r_mepc;
  assign mcause_next   = r_mcause;
  assign mtval_next    = r_mtval;
  assign mstatus_next  = r_mstatus;
  assign priv_lvl_next = r_priv;
  assign busy          = (r_state == FLUSH);
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed, table-driven bench for trap_ctrl (default parameters) with hand-written blackout and reset sequences.
module tb_trap_ctrl;
  localparam int FC = 2;
`ifdef TRAP_VECTORED_EN
  localparam logic VEC = 1'b1;
`else
  localparam logic VEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_en;
  logic [4:0]  exc_code;
  logic [63:0] exc_val;
  logic [15:0] irq_pend, irq_mask;
  logic        mret;
  logic [63:0] pc_addr, mtvec, mstatus_current;
  logic [1:0]  priv_lvl;
  logic        trap_taken, pc_ret_taken, csr_we, busy;
  logic [63:0] pc_trap_next, pc_ret, mepc_next, mcause_next, mtval_next, mstatus_next;
  logic [1:0]  priv_lvl_next;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
    .irq_pend(irq_pend), .irq_mask(irq_mask), .mret(mret), .pc_addr(pc_addr),
    .mtvec(mtvec), .priv_lvl(priv_lvl), .mstatus_current(mstatus_current),
    .trap_taken(trap_taken), .pc_trap_next(pc_trap_next), .pc_ret_taken(pc_ret_taken),
    .pc_ret(pc_ret), .csr_we(csr_we), .mepc_next(mepc_next), .mcause_next(mcause_next),
    .mtval_next(mtval_next), .mstatus_next(mstatus_next), .priv_lvl_next(priv_lvl_next),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc_en;
    logic [4:0]  code;
    logic [63:0] val;
    logic [15:0] pend, mask;
    logic        mret;
    logic [63:0] pc, tvec;
    logic [1:0]  priv;
    logic [63:0] ms;
    logic        e_trap, e_ret;
    logic [63:0] e_pct, e_pcr, e_mepc, e_cause, e_tval, e_ms;
    logic [1:0]  e_priv;
  } vec_t;

  vec_t tv [9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    exc_en = 1'b0; exc_code = '0; exc_val = '0; irq_pend = '0; irq_mask = '0;
    mret = 1'b0; pc_addr = '0; mtvec = 64'h200; priv_lvl = 2'b11; mstatus_current = '0;
  endtask

  function automatic vec_t mk(input logic e, input logic [4:0] c, input logic [63:0] v,
                              input logic [15:0] p, input logic [15:0] m, input logic r,
                              input logic [63:0] pc, input logic [63:0] tvec, input logic [1:0] pr,
                              input logic [63:0] ms, input logic et, input logic er,
                              input logic [63:0] pct, input logic [63:0] pcr, input logic [63:0] mepc,
                              input logic [63:0] cause, input logic [63:0] tval,
                              input logic [63:0] ems, input logic [1:0] epr);
    vec_t t;
    t.exc_en = e; t.code = c; t.val = v; t.pend = p; t.mask = m; t.mret = r;
    t.pc = pc; t.tvec = tvec; t.priv = pr; t.ms = ms;
    t.e_trap = et; t.e_ret = er; t.e_pct = pct; t.e_pcr = pcr; t.e_mepc = mepc;
    t.e_cause = cause; t.e_tval = tval; t.e_ms = ems; t.e_priv = epr;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    string s;
    @(negedge clk);
    exc_en = t.exc_en; exc_code = t.code; exc_val = t.val; irq_pend = t.pend;
    irq_mask = t.mask; mret = t.mret; pc_addr = t.pc; mtvec = t.tvec;
    priv_lvl = t.priv; mstatus_current = t.ms;
    @(negedge clk);
    drive_idle();
    n_vec++;
    s = $sformatf("v%0d", idx);
    chk({s, ".trap_taken"},   64'(trap_taken),   64'(t.e_trap));
    chk({s, ".pc_ret_taken"}, 64'(pc_ret_taken), 64'(t.e_ret));
    chk({s, ".csr_we"},       64'(csr_we),       64'(t.e_trap | t.e_ret));
    chk({s, ".busy"},         64'(busy),         64'(t.e_trap | t.e_ret));
    chk({s, ".pc_trap_next"}, pc_trap_next, t.e_pct);
    chk({s, ".pc_ret"},       pc_ret,       t.e_pcr);
    chk({s, ".mepc_next"},    mepc_next,    t.e_mepc);
    chk({s, ".mcause_next"},  mcause_next,  t.e_cause);
    chk({s, ".mtval_next"},   mtval_next,   t.e_tval);
    chk({s, ".mstatus_next"}, mstatus_next, t.e_ms);
    chk({s, ".priv_lvl_next"}, 64'(priv_lvl_next), 64'(t.e_priv));
    if (t.e_trap | t.e_ret) begin
      repeat (FC) @(negedge clk);
      chk({s, ".busy_end"}, 64'(busy), 64'd0);
    end
    $display("vec %0d: exc=%0b irq=%h mret=%0b -> trap=%0b ret=%0b pct=%h cause=%h",
             idx, t.exc_en, t.pend & t.mask, t.mret, trap_taken, pc_ret_taken,
             pc_trap_next, mcause_next);
  endtask

  localparam logic [63:0] IRQB = 64'h8000_0000_0000_0000;

  initial begin
    rst = 1'b1;
    drive_idle();
    // Vector table: inputs, then expected outputs in the cycle after the sampling edge.
    tv[0] = mk(1, 2, 64'hDEAD, 0, 0, 0, 64'h100, 64'h200, 2'b00, 64'h8,
               1, 0, 64'h200, 0, 64'h100, 64'h2, 64'hDEAD, 64'h80, 2'b11);
    tv[1] = mk(0, 0, 0, 16'h0880, 16'hFFFF, 0, 64'h300, 64'h201, 2'b11, 64'h8,
               1, 0, VEC ? 64'h22C : 64'h200, 0, 64'h300, IRQB | 64'hB, 0, 64'h1880, 2'b11);
    tv[2] = mk(0, 0, 0, 16'h0008, 16'hFFFF, 0, 64'h350, 64'h200, 2'b11, 64'h0,
               0, 0, VEC ? 64'h22C : 64'h200, 0, 64'h300, IRQB | 64'hB, 0, 64'h1880, 2'b11);
    tv[3] = mk(0, 0, 0, 16'h0008, 16'hFFFF, 0, 64'h100, 64'h200, 2'b00, 64'h0,
               1, 0, 64'h200, 0, 64'h100, IRQB | 64'h3, 0, 64'h0, 2'b11);
    tv[4] = mk(0, 0, 0, 0, 0, 1, 64'h444, 64'h200, 2'b11, 64'h80,
               0, 1, 64'h200, 64'h100, 64'h100, IRQB | 64'h3, 0, 64'h88, 2'b00);
    tv[5] = mk(0, 0, 0, 0, 0, 1, 64'h500, 64'h201, 2'b00, 64'h8,
               1, 0, 64'h200, 64'h100, 64'h500, 64'h2, 0, 64'h80, 2'b11);
    tv[6] = mk(0, 0, 0, 16'h0004, 16'hFFFF, 1, 64'h600, 64'h201, 2'b11, 64'h8,
               1, 0, VEC ? 64'h208 : 64'h200, 64'h100, 64'h600, IRQB | 64'h2, 0, 64'h1880, 2'b11);
    tv[7] = mk(1, 7, 64'h55, 16'hFFFF, 16'hFFFF, 1, 64'h700, 64'h201, 2'b11, 64'h8,
               1, 0, 64'h200, 64'h100, 64'h700, 64'h7, 64'h55, 64'h1880, 2'b11);
    tv[8] = mk(0, 0, 0, 16'h8002, 16'h0002, 0, 64'h800, 64'h202, 2'b00, 64'h0,
               1, 0, 64'h200, 64'h100, 64'h800, IRQB | 64'h1, 0, 64'h0, 2'b11);

    repeat (3) @(negedge clk);
    n_vec++;
    chk("rst.trap_taken", 64'(trap_taken), 0);
    chk("rst.pc_ret_taken", 64'(pc_ret_taken), 0);
    chk("rst.csr_we", 64'(csr_we), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.pc_trap_next", pc_trap_next, 0);
    chk("rst.mepc_next", mepc_next, 0);
    chk("rst.mstatus_next", mstatus_next, 0);
    chk("rst.priv_lvl_next", 64'(priv_lvl_next), 64'd3);
    $display("reset: busy=%0b priv_next=%0d", busy, priv_lvl_next);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply(tv[i], i);

    // Exception and irq 5 together, then a second exception during the blackout.
    @(negedge clk);
    exc_en = 1'b1; exc_code = 5'd4; exc_val = 64'h44; pc_addr = 64'hA00;
    irq_pend = 16'h0020; irq_mask = 16'hFFFF; priv_lvl = 2'b00; mstatus_current = 64'h8;
    @(negedge clk);
    n_vec++;
    chk("blk.first_trap", 64'(trap_taken), 1);
    chk("blk.first_cause", mcause_next, 64'h4);
    chk("blk.busy0", 64'(busy), 1);
    exc_code = 5'd6; exc_val = 64'h66;
    $display("blackout: first trap=%0b cause=%h", trap_taken, mcause_next);
    @(negedge clk);
    n_vec++;
    chk("blk.dropped_trap", 64'(trap_taken), 0);
    chk("blk.busy1", 64'(busy), 1);
    chk("blk.cause_held", mcause_next, 64'h4);
    exc_en = 1'b0;
    $display("blackout: second exc trap=%0b busy=%0b", trap_taken, busy);
    @(negedge clk);
    n_vec++;
    chk("blk.no_irq_at_end", 64'(trap_taken), 0);
    chk("blk.busy2", 64'(busy), 0);
    $display("blackout: end busy=%0b", busy);
    @(negedge clk);
    n_vec++;
    chk("blk.irq5_trap", 64'(trap_taken), 1);
    chk("blk.irq5_cause", mcause_next, IRQB | 64'h5);
    $display("blackout: irq5 trap=%0b cause=%h", trap_taken, mcause_next);
    drive_idle();
    repeat (FC) @(negedge clk);

    // Reset asserted while the trap pulse is in flight.
    @(negedge clk);
    exc_en = 1'b1; exc_code = 5'd3; exc_val = 64'h33; pc_addr = 64'hB00;
    @(negedge clk);
    drive_idle();
    n_vec++;
    chk("rmid.trap", 64'(trap_taken), 1);
    rst = 1'b1;
    #1;
    chk("rmid.trap_cleared", 64'(trap_taken), 0);
    chk("rmid.csr_we", 64'(csr_we), 0);
    chk("rmid.busy", 64'(busy), 0);
    chk("rmid.mepc", mepc_next, 0);
    chk("rmid.mcause", mcause_next, 0);
    chk("rmid.priv", 64'(priv_lvl_next), 64'd3);
    $display("reset mid-flush: trap=%0b busy=%0b mepc=%h", trap_taken, busy, mepc_next);
    @(negedge clk);
    rst = 1'b0;
    exc_en = 1'b1; exc_code = 5'd1; exc_val = 64'h11; pc_addr = 64'h900;
    priv_lvl = 2'b00;
    @(negedge clk);
    drive_idle();
    n_vec++;
    chk("rpost.trap", 64'(trap_taken), 1);
    chk("rpost.cause", mcause_next, 64'h1);
    chk("rpost.mepc", mepc_next, 64'h900);
    $display("after reset: trap=%0b cause=%h mepc=%h", trap_taken, mcause_next, mepc_next);
    repeat (FC + 1) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
